trivial_twiddle_rot: RTL and testbench

Parametrised trivial-twiddle rotation stage for the radix-2 FFT datapath, the successor of the fixed ×(−j) factor stage. Per lane it passes the "add" butterfly output unchanged and multiplies the "sub" output by one of {1, −j, −1, +j}. The rotation is chosen per beat from a compile-time table indexed by an internal beat counter. Output is registered behind a valid/ready skid buffer; negation overflow is saturated and reported by a sticky flag.

---
 rtl/trivial_twiddle_rot.sv | 226 ++++++++++++++++++++++
 tb/tb_trivial_twiddle_rot.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivial_twiddle_rot.sv
// Trivial-twiddle rotation stage: add bus passes through, sub bus is rotated by
// {1, -j, -1, +j} from a per-beat table, output held in a valid/ready skid buffer.
module trivial_twiddle_rot #(
   parameter int                 WIDTH     = 10,
   parameter int                 DEPTH     = 16,
   parameter int                 BEATS     = 4,
   parameter logic [2*BEATS-1:0] ROT_TABLE = 8'b11_10_01_00,
   parameter bit                 SAT       = 1'b1,
   localparam int                BW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    byp,
   input  logic                    frm_clr,
   input  logic                    ovf_clr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] din_R_add [DEPTH],
   input  logic signed [WIDTH-1:0] din_Q_add [DEPTH],
   input  logic signed [WIDTH-1:0] din_R_sub [DEPTH],
   input  logic signed [WIDTH-1:0] din_Q_sub [DEPTH],
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] dout_R_add [DEPTH],
   output logic signed [WIDTH-1:0] dout_Q_add [DEPTH],
   output logic signed [WIDTH-1:0] dout_R_sub [DEPTH],
   output logic signed [WIDTH-1:0] dout_Q_sub [DEPTH],
   output logic [BW-1:0]           out_beat,
   output logic                    out_last,
   output logic                    ovf_flag
);

   // Table padded to a power-of-two beat count so the variable part-select never leaves range.
   localparam int                    TW    = 2 * (1 << BW);
   localparam logic [TW-1:0]         TBL   = TW'(ROT_TABLE);
   localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};

   function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] x);
      logic signed [WIDTH-1:0] r;
      if (x == S_MIN) begin
         r = SAT ? S_MAX : S_MIN;
      end else begin
         r = -x;
      end
      return r;
   endfunction

   logic [BW-1:0]           beat_cnt;
   logic [1:0]              code;
   logic                    neg_min;
   logic                    last_in;
   logic                    accept;
   logic                    consume;
   logic                    or_load;
   logic                    sr_load;
   logic                    sr_move;
   logic                    or_valid;
   logic                    sr_valid;
   logic signed [WIDTH-1:0] rot_r [DEPTH];
   logic signed [WIDTH-1:0] rot_q [DEPTH];

   logic signed [WIDTH-1:0] or_ra [DEPTH];
   logic signed [WIDTH-1:0] or_qa [DEPTH];
   logic signed [WIDTH-1:0] or_rs [DEPTH];
   logic signed [WIDTH-1:0] or_qs [DEPTH];
   logic [BW-1:0]           or_beat;
   logic                    or_last;
   logic signed [WIDTH-1:0] sr_ra [DEPTH];
   logic signed [WIDTH-1:0] sr_qa [DEPTH];
   logic signed [WIDTH-1:0] sr_rs [DEPTH];
   logic signed [WIDTH-1:0] sr_qs [DEPTH];
   logic [BW-1:0]           sr_beat;
   logic                    sr_last;

   assign in_ready = ~sr_valid & ~rst;
   assign accept   = in_valid & in_ready;
   assign consume  = or_valid & out_ready;
   assign or_load  = accept & (~or_valid | (consume & ~sr_valid));
   assign sr_load  = accept & or_valid & ~consume;
   assign sr_move  = consume & sr_valid;
   assign last_in  = (beat_cnt == BW'(BEATS - 1));

   // Rotation code for the beat being presented; bypass forces identity.
   always_comb begin
      if (byp) begin
         code = 2'd0;
      end else begin
         code = TBL[{beat_cnt, 1'b0} +: 2];
      end
   end

   // Per-lane rotation of the sub bus and detection of a negated minimum.
   always_comb begin
      neg_min = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rot_r[i] = din_R_sub[i];
         rot_q[i] = din_Q_sub[i];
         case (code)
            2'd0: begin
               rot_r[i] = din_R_sub[i];
               rot_q[i] = din_Q_sub[i];
            end
            2'd1: begin
               rot_r[i] = din_Q_sub[i];
               rot_q[i] = neg_sat(din_R_sub[i]);
               neg_min  = neg_min | (din_R_sub[i] == S_MIN);
            end
            2'd2: begin
               rot_r[i] = neg_sat(din_R_sub[i]);
               rot_q[i] = neg_sat(din_Q_sub[i]);
               neg_min  = neg_min | (din_R_sub[i] == S_MIN) | (din_Q_sub[i] == S_MIN);
            end
            2'd3: begin
               rot_r[i] = neg_sat(din_Q_sub[i]);
               rot_q[i] = din_R_sub[i];
               neg_min  = neg_min | (din_Q_sub[i] == S_MIN);
            end
            default: begin
               rot_r[i] = din_R_sub[i];
               rot_q[i] = din_Q_sub[i];
            end
         endcase
      end
   end

   // Beat counter; a coincident frm_clr lets the current beat keep the old count.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= {BW{1'b0}};
      end else if (frm_clr) begin
         beat_cnt <= {BW{1'b0}};
      end else if (accept) begin
         beat_cnt <= last_in ? {BW{1'b0}} : beat_cnt + BW'(1);
      end
   end

   // Sticky overflow flag, clear wins over set.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_flag <= 1'b0;
      end else if (ovf_clr) begin
         ovf_flag <= 1'b0;
      end else if (accept & neg_min) begin
         ovf_flag <= 1'b1;
      end
   end

   // Output register: loads a fresh beat or the skid contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         or_valid <= 1'b0;
         or_beat  <= {BW{1'b0}};
         or_last  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            or_ra[i] <= {WIDTH{1'b0}};
            or_qa[i] <= {WIDTH{1'b0}};
            or_rs[i] <= {WIDTH{1'b0}};
            or_qs[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (or_load) begin
            or_beat <= beat_cnt;
            or_last <= last_in;
            for (int i = 0; i < DEPTH; i++) begin
               or_ra[i] <= din_R_add[i];
               or_qa[i] <= din_Q_add[i];
               or_rs[i] <= rot_r[i];
               or_qs[i] <= rot_q[i];
            end
         end else if (sr_move) begin
            or_beat <= sr_beat;
            or_last <= sr_last;
            for (int i = 0; i < DEPTH; i++) begin
               or_ra[i] <= sr_ra[i];
               or_qa[i] <= sr_qa[i];
               or_rs[i] <= sr_rs[i];
               or_qs[i] <= sr_qs[i];
            end
         end
         if (or_load | sr_move) begin
            or_valid <= 1'b1;
         end else if (consume) begin
            or_valid <= 1'b0;
         end
      end
   end

   // Skid register: catches a beat accepted while the output is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_valid <= 1'b0;
         sr_beat  <= {BW{1'b0}};
         sr_last  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            sr_ra[i] <= {WIDTH{1'b0}};
            sr_qa[i] <= {WIDTH{1'b0}};
            sr_rs[i] <= {WIDTH{1'b0}};
            sr_qs[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (sr_load) begin
            sr_valid <= 1'b1;
            sr_beat  <= beat_cnt;
            sr_last  <= last_in;
            for (int i = 0; i < DEPTH; i++) begin
               sr_ra[i] <= din_R_add[i];
               sr_qa[i] <= din_Q_add[i];
               sr_rs[i] <= rot_r[i];
               sr_qs[i] <= rot_q[i];
            end
         end else if (sr_move) begin
            sr_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = or_valid;
   assign out_beat   = or_beat;
   assign out_last   = or_last;
   assign dout_R_add = or_ra;
   assign dout_Q_add = or_qa;
   assign dout_R_sub = or_rs;
   assign dout_Q_sub = or_qs;

endmodule

// File: tb/tb_trivial_twiddle_rot.sv
// Self-checking bench: three stage variants (SAT=1, SAT=0, BEATS=1) on shared stimulus,
// checked every cycle against a queue-based behavioural model.
module tb_trivial_twiddle_rot;

   localparam int W    = 10;
   localparam int DEP  = 16;
   localparam int MINV = -512;
   localparam int MAXV = 511;
   localparam int ROT  = 228;  // 8'b11_10_01_00

   typedef struct packed {
      logic [DEP-1:0][W-1:0] ra;
      logic [DEP-1:0][W-1:0] qa;
      logic [DEP-1:0][W-1:0] rs;
      logic [DEP-1:0][W-1:0] qs;
      logic                  byp;
      logic [1:0]            cnt;
   } rec_t;

   logic clk = 1'b0;
   logic rst, in_byp, frm_clr, ovf_clr, in_valid, out_ready;
   logic signed [W-1:0] in_ra [DEP];
   logic signed [W-1:0] in_qa [DEP];
   logic signed [W-1:0] in_rs [DEP];
   logic signed [W-1:0] in_qs [DEP];

   logic signed [W-1:0] o1_ra [DEP], o1_qa [DEP], o1_rs [DEP], o1_qs [DEP];
   logic signed [W-1:0] o2_ra [DEP], o2_qa [DEP], o2_rs [DEP], o2_qs [DEP];
   logic signed [W-1:0] o3_ra [DEP], o3_qa [DEP], o3_rs [DEP], o3_qs [DEP];
   logic       o1_ready, o1_valid, o1_last, o1_ovf;
   logic       o2_ready, o2_valid, o2_last, o2_ovf;
   logic       o3_ready, o3_valid, o3_last, o3_ovf;
   logic [1:0] o1_beat, o2_beat;
   logic [0:0] o3_beat;

   int n_tests = 0;
   int n_fail  = 0;

   rec_t q[$];
   int   mcnt      = 0;
   int   mflag     = 0;
   int   zero_exp  = 1;
   int   model_live = 0;
   int   exp_ready;

   always #5 clk = ~clk;

   trivial_twiddle_rot #(.WIDTH(W), .DEPTH(DEP)) u1 (
      .clk(clk), .rst(rst), .byp(in_byp), .frm_clr(frm_clr), .ovf_clr(ovf_clr),
      .in_valid(in_valid), .in_ready(o1_ready),
      .din_R_add(in_ra), .din_Q_add(in_qa), .din_R_sub(in_rs), .din_Q_sub(in_qs),
      .out_valid(o1_valid), .out_ready(out_ready),
      .dout_R_add(o1_ra), .dout_Q_add(o1_qa), .dout_R_sub(o1_rs), .dout_Q_sub(o1_qs),
      .out_beat(o1_beat), .out_last(o1_last), .ovf_flag(o1_ovf));

   trivial_twiddle_rot #(.WIDTH(W), .DEPTH(DEP), .SAT(1'b0)) u2 (
      .clk(clk), .rst(rst), .byp(in_byp), .frm_clr(frm_clr), .ovf_clr(ovf_clr),
      .in_valid(in_valid), .in_ready(o2_ready),
      .din_R_add(in_ra), .din_Q_add(in_qa), .din_R_sub(in_rs), .din_Q_sub(in_qs),
      .out_valid(o2_valid), .out_ready(out_ready),
      .dout_R_add(o2_ra), .dout_Q_add(o2_qa), .dout_R_sub(o2_rs), .dout_Q_sub(o2_qs),
      .out_beat(o2_beat), .out_last(o2_last), .ovf_flag(o2_ovf));

   trivial_twiddle_rot #(.WIDTH(W), .DEPTH(DEP), .BEATS(1), .ROT_TABLE(2'b00)) u3 (
      .clk(clk), .rst(rst), .byp(in_byp), .frm_clr(frm_clr), .ovf_clr(ovf_clr),
      .in_valid(in_valid), .in_ready(o3_ready),
      .din_R_add(in_ra), .din_Q_add(in_qa), .din_R_sub(in_rs), .din_Q_sub(in_qs),
      .out_valid(o3_valid), .out_ready(out_ready),
      .dout_R_add(o3_ra), .dout_Q_add(o3_qa), .dout_R_sub(o3_rs), .dout_Q_sub(o3_qs),
      .out_beat(o3_beat), .out_last(o3_last), .ovf_flag(o3_ovf));

   function automatic int rot_code(input int k);
      return (ROT >> (2 * k)) & 3;
   endfunction

   function automatic int negv(input int x, input int sat);
      if (x == MINV) return sat ? MAXV : MINV;
      return -x;
   endfunction

   // Complex multiply of (r + jq) by 1, -j, -1, +j.
   function automatic int exp_r(input int r, input int qq, input int c, input int sat);
      case (c)
         1:       return qq;
         2:       return negv(r, sat);
         3:       return negv(qq, sat);
         default: return r;
      endcase
   endfunction

   function automatic int exp_q(input int r, input int qq, input int c, input int sat);
      case (c)
         1:       return negv(r, sat);
         2:       return negv(qq, sat);
         3:       return r;
         default: return qq;
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: two-deep FIFO, beat counter and sticky flag.
   always @(posedge clk) begin
      rec_t r;
      int   c;
      bit   acc, cons, hit;
      model_live = 1;
      if (rst) begin
         q.delete();
         mcnt = 0;
         mflag = 0;
         zero_exp = 1;
      end else begin
         acc  = in_valid && (q.size() < 2);
         cons = (q.size() > 0) && out_ready;
         c    = in_byp ? 0 : rot_code(mcnt);
         hit  = 0;
         for (int i = 0; i < DEP; i++) begin
            r.ra[i] = in_ra[i];
            r.qa[i] = in_qa[i];
            r.rs[i] = in_rs[i];
            r.qs[i] = in_qs[i];
            if ((c == 1 || c == 2) && int'(in_rs[i]) == MINV) hit = 1;
            if ((c == 2 || c == 3) && int'(in_qs[i]) == MINV) hit = 1;
         end
         r.byp = in_byp;
         r.cnt = 2'(mcnt);
         if (ovf_clr) mflag = 0;
         else if (acc && hit) mflag = 1;
         if (frm_clr) mcnt = 0;
         else if (acc) mcnt = (mcnt + 1) % 4;
         if (cons) void'(q.pop_front());
         if (acc) begin
            q.push_back(r);
            zero_exp = 0;
         end
      end
   end

   task automatic check_dut(input int d,
                            input logic signed [W-1:0] ra [DEP], input logic signed [W-1:0] qa [DEP],
                            input logic signed [W-1:0] rs [DEP], input logic signed [W-1:0] qs [DEP],
                            input int valid, input int beat, input int last, input int ovf, input int rdy);
      rec_t r;
      int   c, s, nz;
      int   e[4], a[4], be[4], ba[4], bad[4];
      string p;
      p = $sformatf("dut%0d", d);
      chk({p, " in_ready"}, rdy, exp_ready);
      chk({p, " out_valid"}, valid, (q.size() > 0) ? 1 : 0);
      chk({p, " ovf_flag"}, ovf, (d == 2) ? 0 : mflag);
      if (q.size() > 0) begin
         r = q[0];
         c = (d == 2 || r.byp) ? 0 : rot_code(int'(r.cnt));
         s = (d == 1) ? 0 : 1;
         for (int k = 0; k < 4; k++) bad[k] = 0;
         for (int i = 0; i < DEP; i++) begin
            e[0] = int'($signed(r.ra[i]));
            e[1] = int'($signed(r.qa[i]));
            e[2] = exp_r(int'($signed(r.rs[i])), int'($signed(r.qs[i])), c, s);
            e[3] = exp_q(int'($signed(r.rs[i])), int'($signed(r.qs[i])), c, s);
            a[0] = int'(ra[i]);
            a[1] = int'(qa[i]);
            a[2] = int'(rs[i]);
            a[3] = int'(qs[i]);
            for (int k = 0; k < 4; k++) begin
               if (i == 0 || (bad[k] == 0 && a[k] != e[k])) begin
                  be[k] = e[k];
                  ba[k] = a[k];
                  if (a[k] != e[k]) bad[k] = 1;
               end
            end
         end
         chk({p, " dout_R_add"}, ba[0], be[0]);
         chk({p, " dout_Q_add"}, ba[1], be[1]);
         chk({p, " dout_R_sub"}, ba[2], be[2]);
         chk({p, " dout_Q_sub"}, ba[3], be[3]);
         chk({p, " out_beat"}, beat, (d == 2) ? 0 : int'(r.cnt));
         chk({p, " out_last"}, last, (d == 2 || r.cnt == 2'd3) ? 1 : 0);
      end else if (zero_exp != 0) begin
         nz = 0;
         for (int i = 0; i < DEP; i++) begin
            if (ra[i] != 0 || qa[i] != 0 || rs[i] != 0 || qs[i] != 0) nz = 1;
         end
         chk({p, " dout_zero"}, nz, 0);
         chk({p, " beat_zero"}, beat + last, 0);
      end
   endtask

   // Per-cycle comparison of all three variants against the model.
   always @(negedge clk) begin
      if (model_live != 0) begin
         exp_ready = (!rst && q.size() < 2) ? 1 : 0;
         check_dut(0, o1_ra, o1_qa, o1_rs, o1_qs, int'(o1_valid), int'(o1_beat), int'(o1_last), int'(o1_ovf), int'(o1_ready));
         check_dut(1, o2_ra, o2_qa, o2_rs, o2_qs, int'(o2_valid), int'(o2_beat), int'(o2_last), int'(o2_ovf), int'(o2_ready));
         check_dut(2, o3_ra, o3_qa, o3_rs, o3_qs, int'(o3_valid), int'(o3_beat), int'(o3_last), int'(o3_ovf), int'(o3_ready));
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_lanes(input int ra, input int qa, input int rs, input int qs);
      for (int i = 0; i < DEP; i++) begin
         in_ra[i] = W'(ra);
         in_qa[i] = W'(qa);
         in_rs[i] = W'(rs);
         in_qs[i] = W'(qs);
      end
   endtask

   task automatic send(input int ra, input int qa, input int rs, input int qs);
      set_lanes(ra, qa, rs, qs);
      in_valid = 1'b1;
      step();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      step();
   endtask

   task automatic clr_frame();
      in_valid = 1'b0;
      frm_clr  = 1'b1;
      step();
      frm_clr  = 1'b0;
   endtask

   function automatic logic signed [W-1:0] rnd_sample();
      case ($urandom % 8)
         0:       return W'(MINV);
         1:       return W'(MAXV);
         default: return W'($urandom);
      endcase
   endfunction

   int sweep_r[4] = '{100, -37, -100, 37};
   int sweep_q[4] = '{-37, -100, 37, 100};

   initial begin
      int sent;
      bit acc;
      rst = 1'b1; in_byp = 1'b0; frm_clr = 1'b0; ovf_clr = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1;
      set_lanes(0, 0, 0, 0);
      repeat (3) step();
      chk("ready_in_reset", int'(o1_ready), 0);
      rst = 1'b0;
      step();

      // Hand-computed pins on the model itself.
      chk("model_c1_r", exp_r(100, -37, 1, 1), -37);
      chk("model_c1_q", exp_q(100, -37, 1, 1), -100);
      chk("model_sat_r", exp_r(-512, 7, 2, 1), 511);
      chk("model_wrap_r", exp_r(-512, 7, 2, 0), -512);

      // Rotation sweep, one cycle latency.
      for (int k = 0; k < 4; k++) begin
         send(5, 6, 100, -37);
         chk("sweep_valid", int'(o1_valid), 1);
         chk("sweep_r", int'(o1_rs[0]), sweep_r[k]);
         chk("sweep_q", int'(o1_qs[0]), sweep_q[k]);
         chk("sweep_add", int'(o1_ra[3]) * 1000 + int'(o1_qa[3]), 5006);
         chk("sweep_beat", int'(o1_beat), k);
         chk("sweep_last", int'(o1_last), (k == 3) ? 1 : 0);
      end
      idle();

      // Saturation and wrap of -2^(W-1).
      clr_frame();
      send(1, 2, 3, 4);
      send(1, 2, 3, 4);
      send(0, 0, -512, 7);
      chk("sat_r", int'(o1_rs[0]), 511);
      chk("sat_q", int'(o1_qs[0]), -7);
      chk("wrap_r", int'(o2_rs[0]), -512);
      chk("wrap_q", int'(o2_qs[0]), -7);
      chk("sat_flag", int'(o1_ovf), 1);
      chk("wrap_flag", int'(o2_ovf), 1);
      in_valid = 1'b0;
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("flag_cleared", int'(o1_ovf), 0);
      clr_frame();
      send(1, 2, 3, 4);
      send(1, 2, 3, 4);
      ovf_clr = 1'b1;
      send(0, 0, -512, 7);
      ovf_clr = 1'b0;
      chk("flag_clr_wins", int'(o1_ovf), 0);
      idle();

      // Bypass on beat 1.
      clr_frame();
      send(1, 2, 3, 4);
      in_byp = 1'b1;
      send(0, 0, -512, 3);
      in_byp = 1'b0;
      chk("byp_r", int'(o1_rs[0]), -512);
      chk("byp_q", int'(o1_qs[0]), 3);
      chk("byp_beat", int'(o1_beat), 1);
      chk("byp_flag", int'(o1_ovf), 0);
      idle();

      // Backpressure into the skid register.
      clr_frame();
      sent = 0;
      for (int t = 0; t < 30; t++) begin
         out_ready = (t >= 2 && t <= 5) ? 1'b0 : 1'b1;
         if (sent < 8) begin
            set_lanes(sent, -sent, 10 * sent, 3);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         acc = in_valid && o1_ready;
         step();
         if (acc) sent++;
      end
      chk("bp_all_sent", sent, 8);
      out_ready = 1'b1;

      // frm_clr together with the accept of beat 2.
      clr_frame();
      send(1, 2, 3, 4);
      send(1, 2, 3, 4);
      frm_clr = 1'b1;
      send(0, 0, 100, -37);
      frm_clr = 1'b0;
      chk("fclr_beat", int'(o1_beat), 2);
      chk("fclr_r", int'(o1_rs[0]), -100);
      send(0, 0, 100, -37);
      chk("fclr_next_beat", int'(o1_beat), 0);
      chk("fclr_next_r", int'(o1_rs[0]), 100);
      chk("fclr_next_q", int'(o1_qs[0]), -37);
      chk("b1_last", int'(o3_last), 1);
      idle();

      // Reset with OR and SR both full.
      out_ready = 1'b0;
      send(1, 1, 1, 1);
      send(2, 2, 2, 2);
      chk("skid_full_ready", int'(o1_ready), 0);
      rst = 1'b1;
      send(3, 3, 3, 3);
      chk("rst_valid", int'(o1_valid), 0);
      chk("rst_dout", int'(o1_rs[0]), 0);
      chk("rst_ready", int'(o1_ready), 0);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("post_rst_ready", int'(o1_ready), 1);
      out_ready = 1'b1;
      send(9, 9, 9, 9);
      chk("post_rst_beat", int'(o1_beat), 0);
      chk("post_rst_valid", int'(o1_valid), 1);
      idle();

      // Randomised traffic.
      for (int t = 0; t < 3000; t++) begin
         rst       = ($urandom % 150 == 0);
         in_valid  = ($urandom % 10 < 7);
         out_ready = ($urandom % 10 < 7);
         in_byp    = ($urandom % 10 == 0);
         frm_clr   = ($urandom % 20 == 0);
         ovf_clr   = ($urandom % 20 == 0);
         for (int i = 0; i < DEP; i++) begin
            in_ra[i] = rnd_sample();
            in_qa[i] = rnd_sample();
            in_rs[i] = rnd_sample();
            in_qs[i] = rnd_sample();
         end
         step();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_byp = 1'b0; frm_clr = 1'b0; ovf_clr = 1'b0;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
